sbox_word_arbiter: RTL and testbench

Shared SubWord engine for the AES-256 core. It owns one bank of `LANES` byte S-box lookups and time-shares it between two requesters. Requester A is the round datapath, which issues SubBytes column words. Requester B is the key-expansion unit, which issues SubWord(RotWord) and SubWord words. Grants alternate round-robin, each requester has a one-entry response register with valid/ready backpressure, and throughput is one word per cycle total.

---
 rtl/sbox_word_arbiter.sv | 129 ++++++++++++
 tb/tb_sbox_word_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sbox_word_arbiter.sv
// sbox_word_arbiter: one shared bank of LANES AES forward S-box lookups,
// time-shared round-robin between requester A (round datapath) and
// requester B (key expansion). Each requester gets a one-entry response
// register with valid/ready backpressure; one word per cycle total.
module sbox_word_arbiter #(
    parameter int unsigned LANES    = 4,
    parameter bit          INIT_PRI = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_a_valid,
    output logic                 req_a_ready,
    input  logic [8*LANES-1:0]   req_a_data,
    output logic                 rsp_a_valid,
    input  logic                 rsp_a_ready,
    output logic [8*LANES-1:0]   rsp_a_data,
    input  logic                 req_b_valid,
    output logic                 req_b_ready,
    input  logic [8*LANES-1:0]   req_b_data,
    output logic                 rsp_b_valid,
    input  logic                 rsp_b_ready,
    output logic [8*LANES-1:0]   rsp_b_data
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_t;

    slot_t                slot_a, slot_b, slot_a_next, slot_b_next;
    logic                 pri, pri_next;      // 0 = A holds priority, 1 = B
    logic                 elig_a, elig_b;
    logic                 grant_a, grant_b;
    logic [8*LANES-1:0]   sbox_in, sbox_out;

    // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Forward S-box: multiplicative inverse (v^254, which maps 0 to 0)
    // followed by the AES affine transform.
    function automatic logic [7:0] sbox_byte(input logic [7:0] v);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = v;
        inv = 8'h01;
        for (int unsigned i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    assign rsp_a_valid = (slot_a == FULL);
    assign rsp_b_valid = (slot_b == FULL);

    // Eligibility and round-robin grant; no grants while reset is held
    always_comb begin
        elig_a  = req_a_valid && (!rsp_a_valid || rsp_a_ready);
        elig_b  = req_b_valid && (!rsp_b_valid || rsp_b_ready);
        grant_a = !rst && elig_a && (!elig_b || (pri == 1'b0));
        grant_b = !rst && elig_b && (!elig_a || (pri == 1'b1));
        req_a_ready = grant_a;
        req_b_ready = grant_b;
    end

    // Shared S-box bank fed by the granted requester
    always_comb begin
        sbox_in  = grant_b ? req_b_data : req_a_data;
        sbox_out = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            sbox_out[8*i +: 8] = sbox_byte(sbox_in[8*i +: 8]);
        end
    end

    // Slot next-state and priority update
    always_comb begin
        slot_a_next = slot_a;
        slot_b_next = slot_b;
        pri_next    = pri;
        unique case (slot_a)
            EMPTY: if (grant_a) slot_a_next = FULL;
            FULL:  if (!grant_a && rsp_a_ready) slot_a_next = EMPTY;
            default: slot_a_next = EMPTY;
        endcase
        unique case (slot_b)
            EMPTY: if (grant_b) slot_b_next = FULL;
            FULL:  if (!grant_b && rsp_b_ready) slot_b_next = EMPTY;
            default: slot_b_next = EMPTY;
        endcase
        // only a contested cycle moves priority, to the loser
        if (elig_a && elig_b && !rst) pri_next = grant_a ? 1'b1 : 1'b0;
    end

    // Slot state and priority registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_a <= EMPTY;
            slot_b <= EMPTY;
            pri    <= INIT_PRI;
        end else begin
            slot_a <= slot_a_next;
            slot_b <= slot_b_next;
            pri    <= pri_next;
        end
    end

    // Response data registers, loaded only on grant
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_a_data <= '0;
            rsp_b_data <= '0;
        end else begin
            if (grant_a) rsp_a_data <= sbox_out;
            if (grant_b) rsp_b_data <= sbox_out;
        end
    end

endmodule

// File: tb/tb_sbox_word_arbiter.sv
// Bench for sbox_word_arbiter: per-requester source queues of
// {input, expected} pairs, drivers that move accepted words' expected
// results into scoreboards, and a monitor that checks every completed
// response against the scoreboard head.
module tb_sbox_word_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_a_valid, req_a_ready, rsp_a_valid, rsp_a_ready;
    logic        req_b_valid, req_b_ready, rsp_b_valid, rsp_b_ready;
    logic [31:0] req_a_data, rsp_a_data, req_b_data, rsp_b_data;

    int total = 0;
    int bad   = 0;

    logic [63:0] src_a[$];
    logic [63:0] src_b[$];
    logic [31:0] exp_a[$];
    logic [31:0] exp_b[$];

    sbox_word_arbiter #(.LANES(4), .INIT_PRI(1'b0)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_a_valid (req_a_valid),
        .req_a_ready (req_a_ready),
        .req_a_data  (req_a_data),
        .rsp_a_valid (rsp_a_valid),
        .rsp_a_ready (rsp_a_ready),
        .rsp_a_data  (rsp_a_data),
        .req_b_valid (req_b_valid),
        .req_b_ready (req_b_ready),
        .req_b_data  (req_b_data),
        .rsp_b_valid (rsp_b_valid),
        .rsp_b_ready (rsp_b_ready),
        .rsp_b_data  (rsp_b_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_bit(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Driver A: present source head; on acceptance move its expected value to the scoreboard
    initial begin : drv_a
        logic acc;
        req_a_valid = 1'b0;
        req_a_data  = '0;
        forever begin
            @(negedge clk);
            acc = req_a_valid && req_a_ready && !rst;
            @(posedge clk);
            #1;
            if (acc && src_a.size() > 0) begin
                exp_a.push_back(src_a[0][31:0]);
                void'(src_a.pop_front());
            end
            if (src_a.size() > 0) begin
                req_a_valid = 1'b1;
                req_a_data  = src_a[0][63:32];
            end else begin
                req_a_valid = 1'b0;
            end
        end
    end

    // Driver B: same as driver A
    initial begin : drv_b
        logic acc;
        req_b_valid = 1'b0;
        req_b_data  = '0;
        forever begin
            @(negedge clk);
            acc = req_b_valid && req_b_ready && !rst;
            @(posedge clk);
            #1;
            if (acc && src_b.size() > 0) begin
                exp_b.push_back(src_b[0][31:0]);
                void'(src_b.pop_front());
            end
            if (src_b.size() > 0) begin
                req_b_valid = 1'b1;
                req_b_data  = src_b[0][63:32];
            end else begin
                req_b_valid = 1'b0;
            end
        end
    end

    // Monitor: every completed response must match the scoreboard head
    initial begin : mon
        forever begin
            @(negedge clk);
            if (rsp_a_valid && rsp_a_ready) begin
                if (exp_a.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rsp_a_spurious: got %h expected no response", rsp_a_data);
                end else begin
                    chk("rsp_a_data", rsp_a_data, exp_a[0]);
                    void'(exp_a.pop_front());
                end
            end
            if (rsp_b_valid && rsp_b_ready) begin
                if (exp_b.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rsp_b_spurious: got %h expected no response", rsp_b_data);
                end else begin
                    chk("rsp_b_data", rsp_b_data, exp_b[0]);
                    void'(exp_b.pop_front());
                end
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while ((src_a.size() + src_b.size() + exp_a.size() + exp_b.size()) != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (n >= 200) begin
            total++;
            bad++;
            $display("FAIL wait_idle: got timeout expected drained queues");
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
    endtask

    task automatic wait_rsp(input bit which_b);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(which_b ? rsp_b_valid : rsp_a_valid) && n < 20);
        chk_bit(which_b ? "wait_rsp_b" : "wait_rsp_a", which_b ? rsp_b_valid : rsp_a_valid, 1'b1);
    endtask

    initial begin : main
        int n;
        rst         = 1'b1;
        rsp_a_ready = 1'b1;
        rsp_b_ready = 1'b1;

        // Reset with both requesters valid, then A wins first
        src_a.push_back({32'h00010203, 32'h637c777b});
        src_b.push_back({32'h52525252, 32'h00000000});
        src_b.push_back({32'hffffffff, 32'h16161616});
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_bit("rst_req_a_valid_driven", req_a_valid, 1'b1);
        chk_bit("rst_req_a_ready", req_a_ready, 1'b0);
        chk_bit("rst_req_b_ready", req_b_ready, 1'b0);
        chk_bit("rst_rsp_a_valid", rsp_a_valid, 1'b0);
        chk_bit("rst_rsp_b_valid", rsp_b_valid, 1'b0);
        chk("rst_rsp_a_data", rsp_a_data, 32'h0);
        chk("rst_rsp_b_data", rsp_b_data, 32'h0);
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk_bit("first_grant_a", req_a_ready, 1'b1);
        chk_bit("first_grant_b", req_b_ready, 1'b0);
        wait_idle();

        // Contention: grants alternate A,B,A,B
        do_reset();
        @(posedge clk);
        #2;
        for (int i = 0; i < 4; i++) begin
            src_a.push_back({32'h53535353, 32'hedededed});
            src_b.push_back({32'h00000000, 32'h63636363});
        end
        @(posedge clk);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk_bit("rr_grant_a", req_a_ready, (k % 2) == 0);
            chk_bit("rr_grant_b", req_b_ready, (k % 2) == 1);
        end
        wait_idle();

        // Backpressure on A: B takes every cycle, A's data holds, then back-to-back
        do_reset();
        rsp_a_ready = 1'b0;
        @(posedge clk);
        #2 src_a.push_back({32'h00010203, 32'h637c777b});
        wait_rsp(1'b0);
        @(posedge clk);
        #2;
        src_a.push_back({32'h19a09ae9, 32'hd4e0b81e});
        src_b.push_back({32'h10101010, 32'hcacacaca});
        src_b.push_back({32'h50505050, 32'h53535353});
        src_b.push_back({32'h80808080, 32'hcdcdcdcd});
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_bit("stall_req_a_ready", req_a_ready, 1'b0);
            chk_bit("stall_req_b_ready", req_b_ready, 1'b1);
            chk_bit("stall_rsp_a_valid", rsp_a_valid, 1'b1);
            chk("stall_rsp_a_hold", rsp_a_data, 32'h637c777b);
        end
        @(negedge clk);
        chk_bit("stall_idle_a_ready", req_a_ready, 1'b0);
        chk("stall_rsp_a_hold_end", rsp_a_data, 32'h637c777b);
        @(posedge clk);
        #1 rsp_a_ready = 1'b1;
        @(negedge clk);
        chk_bit("b2b_req_a_ready", req_a_ready, 1'b1);
        chk_bit("b2b_rsp_a_valid", rsp_a_valid, 1'b1);
        wait_idle();

        // Priority retention: uncontested B grants leave A with priority
        do_reset();
        @(posedge clk);
        #2;
        src_b.push_back({32'h30303030, 32'h04040404});
        src_b.push_back({32'h60606060, 32'hd0d0d0d0});
        src_b.push_back({32'h70707070, 32'h51515151});
        n = 0;
        while (src_b.size() > 0 && n < 20) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk("prio_b_drain", 32'(src_b.size()), 32'h0);
        @(posedge clk);
        #2;
        src_a.push_back({32'h19a09ae9, 32'hd4e0b81e});
        src_b.push_back({32'hf0f0f0f0, 32'h8c8c8c8c});
        @(posedge clk);
        @(negedge clk);
        chk_bit("prio_first_a", req_a_ready, 1'b1);
        chk_bit("prio_first_b", req_b_ready, 1'b0);
        @(negedge clk);
        chk_bit("prio_second_b", req_b_ready, 1'b1);
        wait_idle();

        // Asynchronous reset while rsp_b is FULL
        do_reset();
        rsp_b_ready = 1'b0;
        @(posedge clk);
        #2 src_b.push_back({32'h53535353, 32'hedededed});
        wait_rsp(1'b1);
        chk("async_pre_rsp_b_data", rsp_b_data, 32'hedededed);
        #2 rst = 1'b1;
        #1;
        chk_bit("async_rsp_b_valid", rsp_b_valid, 1'b0);
        chk("async_rsp_b_data", rsp_b_data, 32'h0);
        exp_b.delete();
        @(posedge clk);
        #2 rsp_b_ready = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_bit("async_no_stale_b", rsp_b_valid, 1'b0);
        end
        @(posedge clk);
        #2;
        src_a.push_back({32'h00010203, 32'h637c777b});
        src_b.push_back({32'h52525252, 32'h00000000});
        @(posedge clk);
        @(negedge clk);
        chk_bit("post_rst_grant_a", req_a_ready, 1'b1);
        chk_bit("post_rst_grant_b", req_b_ready, 1'b0);
        wait_idle();

        chk("final_exp_a_empty", 32'(exp_a.size()), 32'h0);
        chk("final_exp_b_empty", 32'(exp_b.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
